match_fsm: RTL and testbench
============================

# match_fsm

Match-level sequencer for the ball-and-paddle game. It sits directly downstream of `game_controller` and consumes its `score1`/`score2` outputs. It decides when the ball may move (serve pause after each point), detects the winning score, holds a game-over interval, and issues a score-clear pulse back to the game controller at the start of each match.

## Interface
- `WIN_SCORE`, 11: score at which a player wins; range 1..31.
- `SERVE_DELAY`, 50_000_000: length of the pause before each serve, in cycles; must be ≥1.
- `WIN_HOLD`, 150_000_000: length of the game-over display before returning to IDLE, in cycles; must be ≥1.
- `CNT_W`, 28: width of the shared delay counter; must hold max(SERVE_DELAY, WIN_HOLD)−1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: debounced start request, level; sampled every cycle.
- `score1` in 5: player 1 score from `game_controller`.
- `score2` in 5: player 2 score from `game_controller`.
- `game_en` out 1: ball motion enable, high only in PLAY.
- `score_clr` out 1: one-cycle pulse requesting a score reset.
- `winner` out 2: 00 none, 01 player 1, 10 player 2, 11 draw; valid in WIN.
- `state` out 3: current state encoding, for debug/overlay.

## Operation
- States and encodings: IDLE=0, CLEAR=1, SERVE=2, PLAY=3, WIN=4. Unused encodings go to IDLE on the next cycle.
- IDLE: `start`=1 → CLEAR.
- CLEAR: lasts exactly 1 cycle; `score_clr`=1 during it; → SERVE.
- SERVE: the counter counts from 0; at count==SERVE_DELAY−1 → PLAY. SERVE therefore lasts exactly SERVE_DELAY cycles.
- PLAY: a point event is any cycle where `score1`≠`p1_prev` or `score2`≠`p2_prev`. The prev registers are updated every cycle in every state.
  - On a point event, compare the new scores with WIN_SCORE using ≥ (unsigned, 5-bit):
    - both ≥ → WIN, `winner`=11
    - only score1 ≥ → WIN, `winner`=01
    - only score2 ≥ → WIN, `winner`=10
    - otherwise → SERVE
  - Score changes in any other state are absorbed into prev and never produce a point.
- WIN: the counter counts from 0; at count==WIN_HOLD−1 → IDLE, and `winner` clears to 00 on entry to IDLE. `start` is ignored in WIN.
- The counter resets to 0 on every state change. It does not wrap, because it is always cleared before reaching its limit.
- `start` held high continuously: IDLE→CLEAR immediately after WIN_HOLD expires. This is the auto-restart behaviour and is intended.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `game_en`=0, `score_clr`=0, `winner`=00, counter=0, `p1_prev`=0, `p2_prev`=0.
- `start` high at edge N (in IDLE): CLEAR at N+1 with `score_clr`=1 in that same cycle. SERVE runs from N+2, PLAY from N+2+SERVE_DELAY.
- `game_en` rises in the same cycle state becomes PLAY. It falls in the same cycle state leaves PLAY. It is never high outside PLAY.
- Point detection latency: a score change visible at edge N moves state out of PLAY at N+1. `game_en` is therefore high for at most one cycle after the scoring edge.
- `score_clr` lands at `game_controller` one cycle before SERVE. Scores read 0 before the first PLAY cycle, provided `game_controller` clears within SERVE_DELAY cycles.
- Reset asserted mid-operation, in any state: all outputs go to reset values immediately (asynchronously). On deassertion the block restarts in IDLE.

## Test plan
Bench parameters: WIN_SCORE=3, SERVE_DELAY=4, WIN_HOLD=6, CNT_W=4.

1. Reset then hold idle: `rst`=0, then 1, with `start`=0 for 20 cycles → state=0, `game_en`=0, `score_clr`=0, `winner`=00 throughout.
2. Start sequence: `start` pulse at edge 10 → `score_clr`=1 only in cycle 11; state=2 for cycles 12–15; state=3 and `game_en`=1 from cycle 16.
3. Point without win: in PLAY, `score1` goes 0→1 → next cycle state=2 and `game_en`=0; 4 cycles later state=3 again.
4. Win and draw:
   - In PLAY, `score2` goes 2→3 → state=4, `winner`=10, `game_en`=0. After 6 cycles state=0 and `winner`=00.
   - Repeat with both scores going 2→3 on the same edge → `winner`=11.
5. Scores changing outside PLAY: toggle `score1` during SERVE and during WIN → no extra transitions, and `winner` is unchanged. First PLAY cycle after that shows no spurious point.
6. Reset mid-operation: assert `rst`=0 during SERVE, then during PLAY → `game_en`=0 and state=0 immediately, without waiting for a clock edge. After release with `start`=1, the full CLEAR→SERVE→PLAY sequence repeats with the timing of scenario 2.

Source files
------------

// File: rtl/match_fsm.sv
// Match-level sequencer: serve pause, point/win detection, game-over hold and
// a score-clear pulse to game_controller at the start of each match.
module match_fsm #(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 50_000_000,
  parameter int WIN_HOLD    = 150_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] score1,
  input  logic [4:0] score2,
  output logic       game_en,
  output logic       score_clr,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SERVE = 3'd2,
    PLAY  = 3'd3,
    WIN   = 3'd4
  } state_t;

  localparam logic [4:0]       WIN_LVL    = 5'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_HOLD - 1);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       p1_prev, p2_prev;
  logic             point, p1_win, p2_win;

  assign state  = st;
  assign point  = (score1 != p1_prev) || (score2 != p2_prev);
  assign p1_win = score1 >= WIN_LVL;
  assign p2_win = score2 >= WIN_LVL;

  // Every output is updated on the same edge as the state it belongs to, so
  // game_en / score_clr / winner stay cycle-aligned with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      cnt       <= '0;
      p1_prev   <= '0;
      p2_prev   <= '0;
      game_en   <= 1'b0;
      score_clr <= 1'b0;
      winner    <= 2'b00;
    end else begin
      p1_prev   <= score1;
      p2_prev   <= score2;
      score_clr <= 1'b0;
      case (st)
        IDLE: if (start) begin
          st        <= CLEAR;
          cnt       <= '0;
          score_clr <= 1'b1;
        end
        CLEAR: begin
          st  <= SERVE;
          cnt <= '0;
        end
        SERVE: if (cnt == SERVE_LAST) begin
          st      <= PLAY;
          cnt     <= '0;
          game_en <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        PLAY: if (point) begin
          game_en <= 1'b0;
          cnt     <= '0;
          if (p1_win || p2_win) begin
            st     <= WIN;
            winner <= {p2_win, p1_win};
          end else begin
            st <= SERVE;
          end
        end
        WIN: if (cnt == WIN_LAST) begin
          st     <= IDLE;
          cnt    <= '0;
          winner <= 2'b00;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          st      <= IDLE;
          cnt     <= '0;
          game_en <= 1'b0;
          winner  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_fsm.sv
// Directed, table-driven bench for match_fsm with small delay parameters.
module tb_match_fsm;
  localparam int WS = 3, SD = 4, WH = 6, CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] score1 = '0, score2 = '0;
  logic       game_en, score_clr;
  logic [1:0] winner;
  logic [2:0] state;

  int nvec = 0;
  int nerr = 0;

  match_fsm #(.WIN_SCORE(WS), .SERVE_DELAY(SD), .WIN_HOLD(WH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .score1(score1), .score2(score2),
    .game_en(game_en), .score_clr(score_clr), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [4:0] s1, s2;
    logic [2:0] es;
    logic       ege, eclr;
    logic [1:0] ew;
  } vec_t;

  vec_t q[$];

  task automatic add(input int st, input int s1, input int s2, input int es,
                     input int ege, input int eclr, input int ew);
    vec_t v;
    v.st = 1'(st); v.s1 = 5'(s1); v.s2 = 5'(s2); v.es = 3'(es);
    v.ege = 1'(ege); v.eclr = 1'(eclr); v.ew = 2'(ew);
    q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] es, input logic ege,
                            input logic eclr, input logic [1:0] ew);
    nvec++;
    if (state !== es || game_en !== ege || score_clr !== eclr || winner !== ew) begin
      nerr++;
      $display("FAIL %s: got state=%0d game_en=%b score_clr=%b winner=%b, want state=%0d game_en=%b score_clr=%b winner=%b",
               tag, state, game_en, score_clr, winner, es, ege, eclr, ew);
    end
  endtask

  // Caller has start=1 and reset released; checks CLEAR, SERVE x SD, PLAY.
  task automatic start_seq(input string tag);
    tick(); expect_out({tag, "_clear"}, 3'd1, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < SD; i++) begin
      tick(); expect_out($sformatf("%s_serve%0d", tag, i), 3'd2, 1'b0, 1'b0, 2'b00);
    end
    tick(); expect_out({tag, "_play"}, 3'd3, 1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    // start, s1, s2 -> state, game_en, score_clr, winner
    add(1,0,0, 1,0,1,0);
    add(0,0,0, 2,0,0,0); add(0,0,0, 2,0,0,0); add(0,0,0, 2,0,0,0); add(0,0,0, 2,0,0,0);
    add(0,0,0, 3,1,0,0);
    add(0,1,0, 2,0,0,0);                      // point, no win
    add(0,2,0, 2,0,0,0); add(0,2,0, 2,0,0,0); add(0,2,0, 2,0,0,0); // change absorbed in SERVE
    add(0,2,0, 3,1,0,0); add(0,2,0, 3,1,0,0); // no spurious point
    add(0,2,2, 2,0,0,0);
    add(0,2,2, 2,0,0,0); add(0,2,2, 2,0,0,0); add(0,2,2, 2,0,0,0);
    add(0,2,2, 3,1,0,0);
    add(0,2,3, 4,0,0,2);                      // player 2 wins
    add(0,2,3, 4,0,0,2); add(0,0,3, 4,0,0,2); add(1,2,3, 4,0,0,2);
    add(1,2,3, 4,0,0,2); add(0,2,3, 4,0,0,2);
    add(0,2,3, 0,0,0,0);
    add(1,2,3, 1,0,1,0);
    add(0,0,0, 2,0,0,0); add(0,0,0, 2,0,0,0); add(0,0,0, 2,0,0,0); add(0,0,0, 2,0,0,0);
    add(0,0,0, 3,1,0,0);
    add(0,2,2, 2,0,0,0);
    add(0,2,2, 2,0,0,0); add(0,2,2, 2,0,0,0); add(0,2,2, 2,0,0,0);
    add(0,2,2, 3,1,0,0);
    add(0,3,3, 4,0,0,3);                      // draw
    add(0,3,3, 4,0,0,3); add(0,3,3, 4,0,0,3); add(0,3,3, 4,0,0,3); add(0,3,3, 4,0,0,3);
    add(1,3,3, 4,0,0,3);
    add(1,3,3, 0,0,0,0);                      // start held: auto-restart
    add(1,3,3, 1,0,1,0);
    add(0,3,3, 2,0,0,0); add(0,3,3, 2,0,0,0); add(0,3,3, 2,0,0,0); add(0,3,3, 2,0,0,0);
    add(0,3,3, 3,1,0,0);
    add(0,4,0, 4,0,0,1);                      // player 1 wins

    #3;
    expect_out("in_reset", 3'd0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); expect_out($sformatf("idle%0d", i), 3'd0, 1'b0, 1'b0, 2'b00);
    end

    foreach (q[i]) begin
      start  = q[i].st;
      score1 = q[i].s1;
      score2 = q[i].s2;
      tick();
      expect_out($sformatf("vec%0d", i + 1), q[i].es, q[i].ege, q[i].eclr, q[i].ew);
    end

    // Async reset in WIN, in SERVE, in PLAY: outputs clear without a clock edge.
    start = 1'b0;
    #2 rst = 1'b0;
    #1 expect_out("rst_win", 3'd0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    tick(); expect_out("r1_clear", 3'd1, 1'b0, 1'b1, 2'b00);
    start = 1'b0;
    tick(); expect_out("r1_serve0", 3'd2, 1'b0, 1'b0, 2'b00);
    tick(); expect_out("r1_serve1", 3'd2, 1'b0, 1'b0, 2'b00);
    #2 rst = 1'b0;
    #1 expect_out("rst_serve", 3'd0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    start_seq("r2");
    #2 rst = 1'b0;
    #1 expect_out("rst_play", 3'd0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    start_seq("r3");
    start = 1'b0;
    tick(); expect_out("r3_play_hold", 3'd3, 1'b1, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
